// File: rtl/alarm_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_ctrl
//   Alarm unit that sits behind the BCD HH:MM:SS time counter. Holds a
//   user-settable HH:MM alarm, rings when the time reaches HH:MM:00, and
//   supports snooze plus a timed auto-stop. The stored alarm is exported as
//   four BCD digits in display-scan order.
//
// Ports
//   clk, rst_n         system clock, asynchronous active-low reset
//   tick_1hz           one-clk pulse per second (same enable as time counter)
//   sec0..sec5         current time BCD: s ones/tens, m ones/tens, h ones/tens
//   en_sw              alarm enable switch (asynchronous level)
//   btn_set, btn_inc   raw push buttons (mode step/stop, increment/snooze)
//   alm0..alm3         alarm BCD: min ones/tens, hour ones/tens
//   ringing            high while ringing
//   beep               ringing gated by a 1 s on / 1 s off phase
//   state              FSM state code for LEDs
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module alarm_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic [3:0] sec0,
  input  logic [3:0] sec1,
  input  logic [3:0] sec2,
  input  logic [3:0] sec3,
  input  logic [3:0] sec4,
  input  logic [3:0] sec5,
  input  logic       en_sw,
  input  logic       btn_set,
  input  logic       btn_inc,
  output logic [3:0] alm0,
  output logic [3:0] alm1,
  output logic [3:0] alm2,
  output logic [3:0] alm3,
  output logic       ringing,
  output logic       beep,
  output logic [2:0] state
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_ARMED    = 3'd0,
    ST_SET_HOUR = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_RINGING  = 3'd3,
    ST_SNOOZE   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Button conditioning: sync, debounce, rising-edge pulse (bit 0 = set, 1 = inc)
  // ---------------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] btn_pulse;

  assign btn_raw = {btn_inc, btn_set};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic             sync1_reg;
      logic             sync2_reg;
      logic             deb_reg;
      logic             deb_d_reg;
      logic             pulse_reg;
      logic [DEB_W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          deb_reg   <= 1'b0;
          deb_d_reg <= 1'b0;
          pulse_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          // Count consecutive samples that disagree with the debounced level;
          // any agreeing sample restarts the count, so short glitches vanish.
          if (sync2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
            deb_reg <= sync2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
          deb_d_reg <= deb_reg;
          pulse_reg <= deb_reg & ~deb_d_reg;
        end
      end

      assign btn_pulse[gi] = pulse_reg;
    end
  endgenerate

  // set wins over inc when both pulse together
  logic set_p;
  logic inc_p;
  assign set_p = btn_pulse[0];
  assign inc_p = btn_pulse[1] & ~btn_pulse[0];

  // ---------------------------------------------------------------------------
  // Enable switch synchroniser
  // ---------------------------------------------------------------------------
  logic en_sync1_reg;
  logic en_sync2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sync1_reg <= 1'b0;
      en_sync2_reg <= 1'b0;
    end else begin
      en_sync1_reg <= en_sw;
      en_sync2_reg <= en_sync1_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // State and data registers
  // ---------------------------------------------------------------------------
  state_t      state_reg,      state_next;
  logic [7:0]  alm_hr_reg,     alm_hr_next;   // BCD {tens, ones}
  logic [7:0]  alm_min_reg,    alm_min_next;  // BCD {tens, ones}
  logic [15:0] snz_reg,        snz_next;      // BCD {h tens, h ones, m tens, m ones}
  logic [7:0]  ring_cnt_reg,   ring_cnt_next;
  logic        beep_phase_reg, beep_phase_next;
  logic        match_prev_reg;

  // ---------------------------------------------------------------------------
  // Alarm digit increments (BCD, no carry between hour and minute)
  // ---------------------------------------------------------------------------
  logic [7:0] hr_inc;
  logic [7:0] min_inc;

  always_comb begin
    hr_inc = {alm_hr_reg[7:4], alm_hr_reg[3:0] + 4'd1};
    if (alm_hr_reg == 8'h23) begin
      hr_inc = 8'h00;
    end else if (alm_hr_reg[3:0] == 4'd9) begin
      hr_inc = {alm_hr_reg[7:4] + 4'd1, 4'd0};
    end
  end

  always_comb begin
    min_inc = {alm_min_reg[7:4], alm_min_reg[3:0] + 4'd1};
    if (alm_min_reg[3:0] == 4'd9) begin
      if (alm_min_reg[7:4] == 4'd5) begin
        min_inc = 8'h00;
      end else begin
        min_inc = {alm_min_reg[7:4] + 4'd1, 4'd0};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Snooze target = current HH:MM + SNOOZE_MIN, worked in binary with
  // constant divisors and converted back to BCD.
  // ---------------------------------------------------------------------------
  logic [7:0]  cur_min_bin;
  logic [7:0]  cur_hr_bin;
  logic [7:0]  min_tot;
  logic [7:0]  hr_sum;
  logic [7:0]  snz_min_bin;
  logic [7:0]  snz_hr_bin;
  logic [15:0] snz_calc;

  always_comb begin
    cur_min_bin = {4'd0, sec3} * 8'd10 + {4'd0, sec2};
    cur_hr_bin  = {4'd0, sec5} * 8'd10 + {4'd0, sec4};
    min_tot     = cur_min_bin + 8'(SNOOZE_MIN);
    snz_min_bin = min_tot % 8'd60;
    hr_sum      = cur_hr_bin + (min_tot / 8'd60);
    snz_hr_bin  = hr_sum % 8'd24;
    snz_calc    = {4'(snz_hr_bin / 8'd10), 4'(snz_hr_bin % 8'd10),
                   4'(snz_min_bin / 8'd10), 4'(snz_min_bin % 8'd10)};
  end

  // ---------------------------------------------------------------------------
  // Trigger: edge of the HH:MM:00 match against the active target.
  // Alarm digits are always valid BCD, so malformed time digits never match.
  // ---------------------------------------------------------------------------
  logic [15:0] target;
  logic        match_now;
  logic        fire;

  assign target    = (state_reg == ST_SNOOZE) ? snz_reg : {alm_hr_reg, alm_min_reg};
  assign match_now = ({sec5, sec4, sec3, sec2} == target) && (sec1 == 4'd0) && (sec0 == 4'd0);
  assign fire      = match_now & ~match_prev_reg;

  // ---------------------------------------------------------------------------
  // FSM next state / data
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    alm_hr_next     = alm_hr_reg;
    alm_min_next    = alm_min_reg;
    snz_next        = snz_reg;
    ring_cnt_next   = ring_cnt_reg;
    beep_phase_next = beep_phase_reg;

    case (state_reg)
      ST_ARMED: begin
        if (set_p) begin
          state_next = ST_SET_HOUR;
        end else if (fire && en_sync2_reg) begin
          state_next      = ST_RINGING;
          ring_cnt_next   = '0;
          beep_phase_next = 1'b1;
        end
      end

      ST_SET_HOUR: begin
        if (set_p) begin
          state_next = ST_SET_MIN;
        end else if (inc_p) begin
          alm_hr_next = hr_inc;
        end
      end

      ST_SET_MIN: begin
        if (set_p) begin
          state_next = ST_ARMED;
        end else if (inc_p) begin
          alm_min_next = min_inc;
        end
      end

      ST_RINGING: begin
        if (set_p || !en_sync2_reg) begin
          state_next      = ST_ARMED;
          ring_cnt_next   = '0;
          beep_phase_next = 1'b0;
        end else if (inc_p) begin
          state_next      = ST_SNOOZE;
          snz_next        = snz_calc;
          ring_cnt_next   = '0;
          beep_phase_next = 1'b0;
        end else if (tick_1hz) begin
          if (ring_cnt_reg == 8'(RING_SECS - 1)) begin
            state_next      = ST_ARMED;
            ring_cnt_next   = '0;
            beep_phase_next = 1'b0;
          end else begin
            ring_cnt_next   = ring_cnt_reg + 8'd1;
            beep_phase_next = ~beep_phase_reg;
          end
        end
      end

      ST_SNOOZE: begin
        if (set_p || !en_sync2_reg) begin
          state_next      = ST_ARMED;
          ring_cnt_next   = '0;
          beep_phase_next = 1'b0;
        end else if (fire) begin
          state_next      = ST_RINGING;
          ring_cnt_next   = '0;
          beep_phase_next = 1'b1;
        end
      end

      default: begin
        state_next      = ST_ARMED;
        ring_cnt_next   = '0;
        beep_phase_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_ARMED;
      alm_hr_reg     <= 8'h00;
      alm_min_reg    <= 8'h00;
      snz_reg        <= 16'h0000;
      ring_cnt_reg   <= 8'd0;
      beep_phase_reg <= 1'b0;
      // Starts high so a reset released at 00:00:00 does not ring.
      match_prev_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      alm_hr_reg     <= alm_hr_next;
      alm_min_reg    <= alm_min_next;
      snz_reg        <= snz_next;
      ring_cnt_reg   <= ring_cnt_next;
      beep_phase_reg <= beep_phase_next;
      match_prev_reg <= match_now;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign state   = state_reg;
  assign ringing = (state_reg == ST_RINGING);
  assign beep    = ringing & beep_phase_reg;
  assign alm0    = alm_min_reg[3:0];
  assign alm1    = alm_min_reg[7:4];
  assign alm2    = alm_hr_reg[3:0];
  assign alm3    = alm_hr_reg[7:4];

endmodule

// File: tb/tb_alarm_ctrl.sv
`timescale 1ns/1ps

module tb_alarm_ctrl;

  localparam int DEB  = 16;
  localparam int RING = 60;
  localparam int SNZ  = 5;
  localparam int HOLD = DEB + 6;

  localparam int S_ARMED = 0;
  localparam int S_SETH  = 1;
  localparam int S_SETM  = 2;
  localparam int S_RING  = 3;
  localparam int S_SNZ   = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz;
  logic [3:0] sec0, sec1, sec2, sec3, sec4, sec5;
  logic       en_sw;
  logic       btn_set;
  logic       btn_inc;
  logic [3:0] alm0, alm1, alm2, alm3;
  logic       ringing;
  logic       beep;
  logic [2:0] state;
  logic [15:0] alm_bus;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model (alarm and targets as plain integers)
  int m_hr, m_min, m_state, m_tgt, m_time_hm;

  assign alm_bus = {alm3, alm2, alm1, alm0};

  always #5 clk = ~clk;

  alarm_ctrl #(
    .DEB_CYCLES(DEB),
    .RING_SECS (RING),
    .SNOOZE_MIN(SNZ)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_1hz(tick_1hz),
    .sec0    (sec0),
    .sec1    (sec1),
    .sec2    (sec2),
    .sec3    (sec3),
    .sec4    (sec4),
    .sec5    (sec5),
    .en_sw   (en_sw),
    .btn_set (btn_set),
    .btn_inc (btn_inc),
    .alm0    (alm0),
    .alm1    (alm1),
    .alm2    (alm2),
    .alm3    (alm3),
    .ringing (ringing),
    .beep    (beep),
    .state   (state)
  );

  function automatic logic [15:0] exp_alm(input int h, input int m);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    sec5 = 4'(h / 10);
    sec4 = 4'(h % 10);
    sec3 = 4'(m / 10);
    sec2 = 4'(m % 10);
    sec1 = 4'(s / 10);
    sec0 = 4'(s % 10);
    m_time_hm = h * 60 + m;
  endtask

  task automatic model_reset();
    m_hr = 0;
    m_min = 0;
    m_state = S_ARMED;
    m_tgt = 0;
  endtask

  task automatic model_apply(input bit s, input bit i);
    if (s) begin
      case (m_state)
        S_ARMED: m_state = S_SETH;
        S_SETH:  m_state = S_SETM;
        default: m_state = S_ARMED;
      endcase
    end else if (i) begin
      case (m_state)
        S_SETH: m_hr = (m_hr + 1) % 24;
        S_SETM: m_min = (m_min + 1) % 60;
        S_RING: begin
          m_state = S_SNZ;
          m_tgt = (m_time_hm + SNZ) % 1440;
        end
        default: ;
      endcase
    end
  endtask

  task automatic press(input bit s, input bit i);
    btn_set = s;
    btn_inc = i;
    clk_n(HOLD);
    btn_set = 1'b0;
    btn_inc = 1'b0;
    clk_n(HOLD);
    model_apply(s, i);
    $display("press set=%0b inc=%0b -> model state %0d alarm %02d:%02d", s, i, m_state, m_hr, m_min);
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    clk_n(1);
    tick_1hz = 1'b0;
  endtask

  task automatic program_alarm(input int h, input int m);
    int nh, nm;
    nh = (h - m_hr + 24) % 24;
    press(1'b1, 1'b0);
    repeat (nh) press(1'b0, 1'b1);
    nm = (m - m_min + 60) % 60;
    press(1'b1, 1'b0);
    repeat (nm) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
  endtask

  // Drive the time through a non-match and onto alarm HH:MM:00.
  task automatic get_ringing();
    set_time(m_hr, m_min, 30);
    clk_n(2);
    set_time(m_hr, m_min, 0);
    clk_n(2);
    m_state = S_RING;
    $display("ring at alarm %02d:%02d", m_hr, m_min);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    clk_n(3);
    n_checks++;
    if (state !== 3'd0 || ringing !== 1'b0 || beep !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got state=%0d ringing=%0b beep=%0b required 0/0/0", state, ringing, beep);
    end
    n_checks++;
    if (alm_bus !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_alarm: got %h required 0000", alm_bus);
    end
    rst_n = 1'b1;
    model_reset();
    clk_n(3);
    $display("reset released");
  endtask

  task automatic test_set();
    press(1'b1, 1'b0);
    n_checks++;
    if (state !== 3'(m_state)) begin
      n_fail++;
      $display("FAIL t1_sethour: got state %0d required %0d", state, m_state);
    end
    repeat (7) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    n_checks++;
    if (state !== 3'(m_state)) begin
      n_fail++;
      $display("FAIL t1_setmin: got state %0d required %0d", state, m_state);
    end
    repeat (30) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    n_checks++;
    if (alm_bus !== exp_alm(m_hr, m_min) || state !== 3'(m_state)) begin
      n_fail++;
      $display("FAIL t1_alarm: got %h state %0d required %h state %0d", alm_bus, state, exp_alm(m_hr, m_min), m_state);
    end
  endtask

  task automatic test_wrap();
    press(1'b1, 1'b0);
    for (int k = 0; k < 17; k++) begin
      press(1'b0, 1'b1);
      n_checks++;
      if (alm_bus !== exp_alm(m_hr, m_min)) begin
        n_fail++;
        $display("FAIL t2_hour_inc: got %h required %h", alm_bus, exp_alm(m_hr, m_min));
      end
    end
    press(1'b1, 1'b0);
    repeat (29) press(1'b0, 1'b1);
    n_checks++;
    if (alm_bus !== exp_alm(m_hr, m_min)) begin
      n_fail++;
      $display("FAIL t2_min59: got %h required %h", alm_bus, exp_alm(m_hr, m_min));
    end
    press(1'b0, 1'b1);
    n_checks++;
    if (alm_bus !== exp_alm(m_hr, m_min)) begin
      n_fail++;
      $display("FAIL t2_min_wrap: got %h required %h", alm_bus, exp_alm(m_hr, m_min));
    end
    press(1'b1, 1'b0);
  endtask

  task automatic test_random_edit();
    int nh, nm;
    for (int r = 0; r < 3; r++) begin
      nh = $urandom_range(0, 25);
      nm = $urandom_range(0, 15);
      press(1'b1, 1'b0);
      for (int k = 0; k < nh; k++) begin
        press(1'b0, 1'b1);
        n_checks++;
        if (alm_bus !== exp_alm(m_hr, m_min)) begin
          n_fail++;
          $display("FAIL rand_hour: got %h required %h", alm_bus, exp_alm(m_hr, m_min));
        end
      end
      press(1'b1, 1'b0);
      for (int k = 0; k < nm; k++) begin
        press(1'b0, 1'b1);
        n_checks++;
        if (alm_bus !== exp_alm(m_hr, m_min)) begin
          n_fail++;
          $display("FAIL rand_min: got %h required %h", alm_bus, exp_alm(m_hr, m_min));
        end
      end
      press(1'b1, 1'b0);
      n_checks++;
      if (state !== 3'(m_state)) begin
        n_fail++;
        $display("FAIL rand_back_armed: got %0d required %0d", state, m_state);
      end
    end
  endtask

  task automatic test_ring();
    program_alarm(7, 30);
    set_time(7, 29, 59);
    clk_n(3);
    set_time(7, 30, 0);
    n_checks++;
    if (ringing !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_no_early_ring: got %0b required 0", ringing);
    end
    clk_n(1);
    m_state = S_RING;
    n_checks++;
    if (ringing !== 1'b1 || beep !== 1'b1 || state !== 3'(m_state)) begin
      n_fail++;
      $display("FAIL t3_ring_start: got ring=%0b beep=%0b state=%0d required 1/1/%0d", ringing, beep, state, m_state);
    end
    for (int k = 1; k <= RING; k++) begin
      clk_n($urandom_range(0, 3));
      tick();
      if (k < RING) begin
        n_checks++;
        if (ringing !== 1'b1 || beep !== ((k % 2) == 0)) begin
          n_fail++;
          $display("FAIL t3_tick%0d: got ring=%0b beep=%0b required 1/%0b", k, ringing, beep, (k % 2) == 0);
        end
      end else begin
        m_state = S_ARMED;
        n_checks++;
        if (ringing !== 1'b0 || state !== 3'(m_state)) begin
          n_fail++;
          $display("FAIL t3_autostop: got ring=%0b state=%0d required 0/%0d", ringing, state, m_state);
        end
      end
    end
    $display("ring auto-stop after %0d ticks", RING);
  endtask

  task automatic test_snooze();
    int th, tm, t;
    get_ringing();
    n_checks++;
    if (ringing !== 1'b1) begin
      n_fail++;
      $display("FAIL t4_ring_first: got %0b required 1", ringing);
    end
    for (int r = 0; r < 6; r++) begin
      th = (r == 0) ? 23 : $urandom_range(0, 23);
      tm = (r == 0) ? 58 : $urandom_range(0, 59);
      set_time(th, tm, 30);
      clk_n(2);
      press(1'b0, 1'b1);
      n_checks++;
      if (state !== 3'(m_state) || ringing !== 1'b0) begin
        n_fail++;
        $display("FAIL snooze_enter: got state=%0d ring=%0b required %0d/0", state, ringing, m_state);
      end
      t = (m_tgt + 1439) % 1440;
      set_time(t / 60, t % 60, 0);
      clk_n(3);
      set_time(m_tgt / 60, m_tgt % 60, 1);
      clk_n(3);
      n_checks++;
      if (state !== 3'(m_state)) begin
        n_fail++;
        $display("FAIL snooze_near_miss: got state=%0d required %0d", state, m_state);
      end
      set_time(m_tgt / 60, m_tgt % 60, 0);
      clk_n(1);
      m_state = S_RING;
      n_checks++;
      if (ringing !== 1'b1 || beep !== 1'b1) begin
        n_fail++;
        $display("FAIL snooze_refire %02d:%02d+%0d: got ring=%0b beep=%0b required 1/1", th, tm, SNZ, ringing, beep);
      end
      $display("snooze from %02d:%02d refired at %02d:%02d", th, tm, m_tgt / 60, m_tgt % 60);
    end
    press(1'b1, 1'b0);
    n_checks++;
    if (state !== 3'(m_state) || beep !== 1'b0 || ringing !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_stop: got state=%0d beep=%0b ring=%0b required %0d/0/0", state, beep, ringing, m_state);
    end
  endtask

  task automatic test_edge();
    set_time(12, 0, 30);
    clk_n(2);
    press(1'b1, 1'b1);
    n_checks++;
    if (state !== 3'(m_state) || alm_bus !== exp_alm(m_hr, m_min)) begin
      n_fail++;
      $display("FAIL t5_both_armed: got state=%0d alm=%h required %0d/%h", state, alm_bus, m_state, exp_alm(m_hr, m_min));
    end
    press(1'b1, 1'b1);
    n_checks++;
    if (state !== 3'(m_state) || alm_bus !== exp_alm(m_hr, m_min)) begin
      n_fail++;
      $display("FAIL t5_both_sethour: got state=%0d alm=%h required %0d/%h", state, alm_bus, m_state, exp_alm(m_hr, m_min));
    end
    // match while editing minutes must not fire on the way back to ARMED
    set_time(m_hr, m_min, 30);
    clk_n(2);
    set_time(m_hr, m_min, 0);
    clk_n(3);
    press(1'b1, 1'b0);
    clk_n(5);
    n_checks++;
    if (ringing !== 1'b0 || state !== 3'(m_state)) begin
      n_fail++;
      $display("FAIL t5_no_retro_fire: got ring=%0b state=%0d required 0/%0d", ringing, state, m_state);
    end

    get_ringing();
    en_sw = 1'b0;
    clk_n(1);
    n_checks++;
    if (ringing !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_en_sync_delay: got ring=%0b required 1", ringing);
    end
    clk_n(2);
    m_state = S_ARMED;
    n_checks++;
    if (state !== 3'(m_state)) begin
      n_fail++;
      $display("FAIL t5_en_off_ring: got state=%0d required %0d", state, m_state);
    end

    set_time(m_hr, m_min, 30);
    clk_n(2);
    set_time(m_hr, m_min, 0);
    clk_n(3);
    en_sw = 1'b1;
    clk_n(4);
    n_checks++;
    if (ringing !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_en_off_armed: got ring=%0b required 0", ringing);
    end

    set_time(m_hr, m_min, 30);
    clk_n(2);
    sec1 = 4'd0;
    sec0 = 4'hA;
    clk_n(3);
    n_checks++;
    if (ringing !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_bad_bcd: got ring=%0b required 0", ringing);
    end

    set_time(0, 0, 0);
    clk_n(1);
    rst_n = 1'b0;
    clk_n(2);
    rst_n = 1'b1;
    model_reset();
    clk_n(6);
    n_checks++;
    if (ringing !== 1'b0 || state !== 3'(m_state) || alm_bus !== exp_alm(m_hr, m_min)) begin
      n_fail++;
      $display("FAIL t5_reset_midnight: got ring=%0b state=%0d alm=%h required 0/%0d/%h", ringing, state, alm_bus, m_state, exp_alm(m_hr, m_min));
    end
  endtask

  task automatic test_debounce();
    set_time(9, 15, 30);
    clk_n(2);
    btn_set = 1'b1;
    clk_n(DEB - 3);
    btn_set = 1'b0;
    clk_n(2 * DEB);
    n_checks++;
    if (state !== 3'(m_state)) begin
      n_fail++;
      $display("FAIL t6_glitch: got state=%0d required %0d", state, m_state);
    end

    for (int b = 0; b < 4; b++) begin
      btn_set = 1'b1;
      clk_n($urandom_range(1, DEB - 3));
      btn_set = 1'b0;
      clk_n($urandom_range(1, 4));
    end
    btn_set = 1'b1;
    clk_n(DEB + 3);
    n_checks++;
    if (state !== 3'(m_state)) begin
      n_fail++;
      $display("FAIL t6_early: got state=%0d required %0d", state, m_state);
    end
    clk_n(1);
    model_apply(1'b1, 1'b0);
    n_checks++;
    if (state !== 3'(m_state)) begin
      n_fail++;
      $display("FAIL t6_latency: got state=%0d required %0d", state, m_state);
    end
    clk_n(HOLD);
    btn_set = 1'b0;
    clk_n(HOLD);
    n_checks++;
    if (state !== 3'(m_state)) begin
      n_fail++;
      $display("FAIL t6_single_pulse: got state=%0d required %0d", state, m_state);
    end
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);

    get_ringing();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (state !== 3'd0 || ringing !== 1'b0 || beep !== 1'b0 || alm_bus !== 16'h0000) begin
      n_fail++;
      $display("FAIL t6_async_reset: got state=%0d ring=%0b beep=%0b alm=%h required 0/0/0/0000", state, ringing, beep, alm_bus);
    end
    #2;
    rst_n = 1'b1;
    clk_n(3);
    $display("async reset applied mid-ring");
  endtask

  initial begin
    rst_n = 1'b0;
    tick_1hz = 1'b0;
    en_sw = 1'b1;
    btn_set = 1'b0;
    btn_inc = 1'b0;
    set_time(12, 0, 30);
    model_reset();
    test_reset();
    test_set();
    test_wrap();
    test_random_edit();
    test_ring();
    test_snooze();
    test_edge();
    test_debounce();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "time limit");
  end

endmodule
